// File: rtl/mtr_pwm_drv.sv
// mtr_pwm_drv: dual-channel motor PWM stage with dead-time insertion.
// Signed 11-bit wheel speeds are offset to unsigned duty values. The duty is
// latched once per 2048-clock period and compared against a shared free-running
// timebase. Each channel drives a complementary PWM pair with a dead window.
// Optional feature: define PWM_SYNC_EN to add the pwm_sync period-start strobe.
module mtr_pwm_drv #(
    parameter int DEAD_CYC = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        lftPWM1,
    output logic        lftPWM2,
    output logic        rghtPWM1,
    output logic        rghtPWM2
`ifdef PWM_SYNC_EN
    ,
    output logic        pwm_sync
`endif
);

    localparam logic [5:0]  DEAD_LOAD = 6'(DEAD_CYC);
    localparam logic [10:0] CNT_LAST  = 11'h7FF;
    localparam logic [10:0] DUTY_ZERO = 11'h400;

    logic [10:0] cnt_q;
    logic [10:0] cnt_d;
    logic [1:0]  pwm1_w;
    logic [1:0]  pwm2_w;

    // Shared timebase simply wraps every 2048 clocks.
    always_comb begin
        cnt_d = cnt_q + 11'd1;
    end

    // Timebase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 11'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [10:0] spd_w;
            logic [10:0] duty_q, duty_d;
            logic        raw_q, raw_d;
            logic [5:0]  dead_q, dead_d;
            logic        pwm1_q, pwm1_d;
            logic        pwm2_q, pwm2_d;

            assign spd_w = (gi == 0) ? lft_spd : rght_spd;

            // Duty latch, raw compare and dead-time window for this channel.
            always_comb begin
                // Offsetting by 0x400 is the same as flipping the sign bit.
                duty_d = (cnt_q == CNT_LAST) ? {~spd_w[10], spd_w[9:0]} : duty_q;
                raw_d  = (cnt_q < duty_q);
                dead_d = dead_q;
                pwm1_d = 1'b0;
                pwm2_d = 1'b0;
                if (raw_d != raw_q) begin
                    // Any raw edge (re)opens the window; both sides go low now.
                    dead_d = DEAD_LOAD;
                end else if (dead_q != 6'd0) begin
                    dead_d = dead_q - 6'd1;
                end else begin
                    pwm1_d = raw_q;
                    pwm2_d = ~raw_q;
                end
            end

            // Per-channel state; reset parks both drives low at zero speed.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    duty_q <= DUTY_ZERO;
                    raw_q  <= 1'b0;
                    dead_q <= 6'd0;
                    pwm1_q <= 1'b0;
                    pwm2_q <= 1'b0;
                end else begin
                    duty_q <= duty_d;
                    raw_q  <= raw_d;
                    dead_q <= dead_d;
                    pwm1_q <= pwm1_d;
                    pwm2_q <= pwm2_d;
                end
            end

            assign pwm1_w[gi] = pwm1_q;
            assign pwm2_w[gi] = pwm2_q;
        end
    endgenerate

    assign lftPWM1  = pwm1_w[0];
    assign lftPWM2  = pwm2_w[0];
    assign rghtPWM1 = pwm1_w[1];
    assign rghtPWM2 = pwm2_w[1];

`ifdef PWM_SYNC_EN
    logic pwm_sync_q;
    logic pwm_sync_d;

    // Strobe lands in the cycle where the counter reads zero after a wrap.
    always_comb begin
        pwm_sync_d = (cnt_q == CNT_LAST);
    end

    // Registered strobe so it is clean for the upstream consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_sync_q <= 1'b0;
        end else begin
            pwm_sync_q <= pwm_sync_d;
        end
    end

    assign pwm_sync = pwm_sync_q;
`endif

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Testbench for mtr_pwm_drv: per-period high-time counts from a vector table,
// mid-period speed change, asynchronous reset, and (with PWM_SYNC_EN) the sync strobe.
module tb_mtr_pwm_drv;

    localparam int DEAD_CYC = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] lft_spd = 11'd0;
    logic [10:0] rght_spd = 11'd0;
    logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2;
`ifdef PWM_SYNC_EN
    logic        pwm_sync;
`endif

    mtr_pwm_drv #(.DEAD_CYC(DEAD_CYC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .lftPWM1  (lftPWM1),
        .lftPWM2  (lftPWM2),
        .rghtPWM1 (rghtPWM1),
        .rghtPWM2 (rghtPWM2)
`ifdef PWM_SYNC_EN
        ,
        .pwm_sync (pwm_sync)
`endif
    );

    always #5 clk = ~clk;

    // Bench's own notion of the period position: clocks since reset release.
    logic [10:0] tb_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 11'd0;
        else        tb_cnt <= tb_cnt + 11'd1;
    end

    int checks = 0;
    int failures = 0;
    int l_ovl = 0;
    int r_ovl = 0;

    // Complementary outputs must never overlap.
    always @(negedge clk) begin
        if (lftPWM1 && lftPWM2)   l_ovl++;
        if (rghtPWM1 && rghtPWM2) r_ovl++;
    end

    typedef struct {
        logic [10:0] lft;
        logic [10:0] rght;
        int          l1;
        int          l2;
        int          r1;
        int          r2;
    } vec_t;

    vec_t vecs[6];
    vec_t sb_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counts high cycles of every output over one period (cnt 0..0x7FF).
    // Optionally changes lft_spd when the period reaches cnt 0x200.
    task automatic measure(input bit chg, input logic [10:0] chg_val,
                           output int l1, output int l2, output int r1, output int r2);
        int guard;
        guard = 0;
        l1 = 0; l2 = 0; r1 = 0; r2 = 0;
        while (tb_cnt != 11'd0 && guard < 2100) begin
            @(negedge clk);
            guard++;
        end
        if (tb_cnt != 11'd0) begin
            checks++;
            failures++;
            $display("FAIL period_align: got cnt %0d expected 0", tb_cnt);
        end else begin
            for (int i = 0; i < 2048; i++) begin
                if (i > 0) @(negedge clk);
                if (chg && i == 'h200) lft_spd = chg_val;
                l1 += int'(lftPWM1);
                l2 += int'(lftPWM2);
                r1 += int'(rghtPWM1);
                r2 += int'(rghtPWM2);
            end
        end
    endtask

    initial begin
        int l1, l2, r1, r2;
        int first_l, first_r, pwm2_seen, guard;
        vec_t exp_v;

        // {lft, rght, lftPWM1, lftPWM2, rghtPWM1, rghtPWM2 high clocks per period}
        vecs[0] = '{11'h000, 11'h000,  991,  991,  991,  991};
        vecs[1] = '{11'h400, 11'h3FF,    0, 2048, 2014,    0};
        vecs[2] = '{11'h200, 11'h600, 1503,  479,  479, 1503};
        vecs[3] = '{11'h3FF, 11'h400, 2014,    0,    0, 2048};
        vecs[4] = '{11'h418, 11'h3E8,    0, 1991, 1991,    0};
        vecs[5] = '{11'h064, 11'h6D4, 1091,  891,  691, 1291};

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_lftPWM1", int'(lftPWM1), 0);
        check("rst_lftPWM2", int'(lftPWM2), 0);
        check("rst_rghtPWM1", int'(rghtPWM1), 0);
        check("rst_rghtPWM2", int'(rghtPWM2), 0);
`ifdef PWM_SYNC_EN
        check("rst_pwm_sync", int'(pwm_sync), 0);
`endif
        rst_n = 1'b1;

        // First period after release is used only for alignment.
        measure(1'b0, 11'd0, l1, l2, r1, r2);

        // Table vectors: drive at period end, skip the transition period, measure.
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(vecs[i]);
            lft_spd  = vecs[i].lft;
            rght_spd = vecs[i].rght;
            measure(1'b0, 11'd0, l1, l2, r1, r2);
            measure(1'b0, 11'd0, l1, l2, r1, r2);
            exp_v = sb_q.pop_front();
            $display("vec %0d lft=%h rght=%h : l1=%0d l2=%0d r1=%0d r2=%0d",
                     i, exp_v.lft, exp_v.rght, l1, l2, r1, r2);
            check($sformatf("vec%0d_lftPWM1", i), l1, exp_v.l1);
            check($sformatf("vec%0d_lftPWM2", i), l2, exp_v.l2);
            check($sformatf("vec%0d_rghtPWM1", i), r1, exp_v.r1);
            check($sformatf("vec%0d_rghtPWM2", i), r2, exp_v.r2);
        end

        // Mid-period change: 0 -> +512 at cnt 0x200 must wait for the wrap.
        lft_spd  = 11'h000;
        rght_spd = 11'h000;
        measure(1'b0, 11'd0, l1, l2, r1, r2);
        sb_q.push_back('{11'h000, 11'h000, 991, 0, 0, 0});
        sb_q.push_back('{11'h200, 11'h000, 1503, 0, 0, 0});
        measure(1'b1, 11'h200, l1, l2, r1, r2);
        exp_v = sb_q.pop_front();
        $display("midchg current period : l1=%0d", l1);
        check("midchg_hold_lftPWM1", l1, exp_v.l1);
        measure(1'b0, 11'd0, l1, l2, r1, r2);
        exp_v = sb_q.pop_front();
        $display("midchg next period : l1=%0d", l1);
        check("midchg_next_lftPWM1", l1, exp_v.l1);

        // Asynchronous reset at cnt 0x300 while lftPWM1 is high.
        lft_spd = 11'h000;
        guard = 0;
        @(negedge clk);
        while (tb_cnt != 11'h300 && guard < 4200) begin
            @(negedge clk);
            guard++;
        end
        check("prerst_cnt", int'(tb_cnt), 'h300);
        check("prerst_lftPWM1", int'(lftPWM1), 1);
        #2 rst_n = 1'b0;
        #1;
        check("asyncrst_lftPWM1", int'(lftPWM1), 0);
        check("asyncrst_lftPWM2", int'(lftPWM2), 0);
        check("asyncrst_rghtPWM1", int'(rghtPWM1), 0);
        check("asyncrst_rghtPWM2", int'(rghtPWM2), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        first_l = -1;
        first_r = -1;
        pwm2_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (lftPWM1 && first_l < 0)  first_l = int'(tb_cnt);
            if (rghtPWM1 && first_r < 0) first_r = int'(tb_cnt);
            if (lftPWM2 || rghtPWM2)     pwm2_seen = 1;
        end
        $display("post-reset first rise : lft=%0d rght=%0d", first_l, first_r);
        // raw rises on clock 1; PWM1 follows DEAD_CYC+1 clocks later.
        check("postrst_lft_rise", first_l, DEAD_CYC + 2);
        check("postrst_rght_rise", first_r, DEAD_CYC + 2);
        check("postrst_pwm2_low", pwm2_seen, 0);

`ifdef PWM_SYNC_EN
        begin
            int n;
            int cyc;
            int at[3];
            int cv[3];
            n = 0;
            cyc = 0;
            while (n < 3 && cyc < 7000) begin
                @(negedge clk);
                cyc++;
                if (pwm_sync) begin
                    at[n] = cyc;
                    cv[n] = int'(tb_cnt);
                    n++;
                end
            end
            check("sync_pulse_count", n, 3);
            if (n == 3) begin
                $display("pwm_sync pulses at cycles %0d %0d %0d", at[0], at[1], at[2]);
                for (int p = 0; p < 3; p++) check($sformatf("sync%0d_cnt", p), cv[p], 0);
                check("sync_gap01", at[1] - at[0], 2048);
                check("sync_gap12", at[2] - at[1], 2048);
            end
        end
`endif

        check("overlap_left", l_ovl, 0);
        check("overlap_right", r_ovl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
